doled_serializer: RTL and testbench

Serial LED frame transmitter for the wand's APA102-style LED string. It accepts one 32-bit frame per handshake from the string generator (start frame, one tri-colour LED frame, or end frame) and shifts it out MSB-first on `mosi`/`sck`. It drives `doled_busy` back to the generator for flow control, and sits directly between the string generator and the board LED pins.

---
 rtl/doled_pkg.sv | 44 ++++
 rtl/doled_sck_div.sv | 64 ++++++
 rtl/doled_serializer.sv | 150 +++++++++++++++
 tb/tb_doled_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/doled_pkg.sv
// -----------------------------------------------------------------------------
// doled_pkg
//
// Purpose:
//   Shared definitions for the APA102-style LED serializer and the string
//   generator that feeds it. This covers the frame-type codes, the frame
//   geometry, the LED frame header, the FSM state encoding, and a helper that
//   packs an LED frame word.
//
// Contents:
//   INPUT_TYPE_*   2-bit frame type codes presented on type_input
//   FRAME_BITS     bits per serial frame (32)
//   LED_HEADER     fixed 3-bit header at the top of every LED frame
//   doled_state_e  serializer FSM states (IDLE, SHIFT)
//   led_word()     assembles {header, brightness, blue, green, red}
// -----------------------------------------------------------------------------
package doled_pkg;

  localparam logic [1:0] INPUT_TYPE_START   = 2'd0;
  localparam logic [1:0] INPUT_TYPE_LED     = 2'd1;
  localparam logic [1:0] INPUT_TYPE_END     = 2'd2;
  localparam logic [1:0] INPUT_TYPE_INVALID = 2'd3;

  localparam int FRAME_BITS = 32;

  localparam logic [2:0] LED_HEADER = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } doled_state_e;

  // LED frame layout, MSB first on the wire: header, 5-bit global brightness,
  // then blue, green, red.
  function automatic logic [FRAME_BITS-1:0] led_word(
    input logic [4:0] bright,
    input logic [7:0] blue,
    input logic [7:0] green,
    input logic [7:0] red
  );
    return {LED_HEADER, bright, blue, green, red};
  endfunction

endpackage

// File: rtl/doled_sck_div.sv
// -----------------------------------------------------------------------------
// doled_sck_div
//
// Purpose:
//   This block generates the serial clock for the LED serializer. While
//   i_run is high, a divider counts 0..CLK_DIV-1. Each wrap toggles sck, so
//   one sck half-period lasts CLK_DIV clock cycles. The block also flags the
//   cycle on which a toggle will happen, using one-cycle strobes. The
//   serializer acts on these strobes at the same edge where sck changes.
//   While i_run is low, the divider is held at 0 and sck is held low. The
//   first rising edge of sck therefore comes exactly CLK_DIV cycles after
//   i_run rises.
//
// Parameters:
//   CLK_DIV      sck half-period in i_clk cycles, 1..255
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_run        enable; low clears the divider and parks sck low
//   o_sck        registered serial clock
//   o_rise_tick  high on the cycle whose closing edge drives sck 0->1
//   o_fall_tick  high on the cycle whose closing edge drives sck 1->0
// -----------------------------------------------------------------------------
module doled_sck_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_sck,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_sck;
  logic       w_wrap;

  // The wrap is an explicit compare against the last count. The counter never
  // relies on natural overflow, so every CLK_DIV in 1..255 behaves the same.
  assign w_wrap      = i_run && (r_div_cnt == DIV_LAST);
  assign o_rise_tick = w_wrap && !r_sck;
  assign o_fall_tick = w_wrap &&  r_sck;
  assign o_sck       = r_sck;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values. Blocking assignments here would let later
  // statements see updated values and silently reorder the pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_div_cnt <= 8'd0;
      r_sck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= 8'd0;
      r_sck     <= !r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/doled_serializer.sv
// -----------------------------------------------------------------------------
// doled_serializer
//
// Purpose:
//   This is the serial frame transmitter for an APA102-style LED string. It
//   accepts one 32-bit frame (START, LED or END) per handshake and shifts it
//   out MSB-first on mosi/sck. The frame goes out with mosi changing only on
//   sck falling edges, so the data is stable at every rising edge.
//   doled_busy is high for exactly 64*CLK_DIV cycles per frame. It drops
//   together with the final sck fall, so the next request can be accepted on
//   the first cycle that busy is low.
//
// Build option:
//   DOLED_BRIGHTNESS_EN  when defined, the brightness_input port exists and is
//                        latched into bits [28:24] of LED frames. When it is
//                        undefined, that field is fixed at 5'b11111.
//
// Parameters:
//   CLK_DIV     sck half-period in doled_clk cycles, 1..255
//   START_WORD  start frame content
//   END_WORD    end frame content
//
// Ports:
//   doled_clk         clock
//   doled_reset       synchronous, active-high reset (wins over doled_start)
//   doled_start       frame request, sampled only while doled_busy = 0
//   type_input        frame type: 0 START, 1 LED, 2 END, 3 invalid (ignored)
//   blue_input        LED blue byte
//   green_input       LED green byte
//   red_input         LED red byte
//   brightness_input  LED global brightness (DOLED_BRIGHTNESS_EN only)
//   doled_busy        frame in progress
//   mosi              serial data
//   sck               serial clock
// -----------------------------------------------------------------------------
module doled_serializer
  import doled_pkg::*;
#(
  parameter int          CLK_DIV    = 2,
  parameter logic [31:0] START_WORD = 32'h0000_0000,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
  input  logic       doled_clk,
  input  logic       doled_reset,
  input  logic       doled_start,
  input  logic [1:0] type_input,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
`ifdef DOLED_BRIGHTNESS_EN
  input  logic [4:0] brightness_input,
`endif
  output logic       doled_busy,
  output logic       mosi,
  output logic       sck
);

  doled_state_e          r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [4:0]            r_bit_cnt;
  // Armed on the sck rise that presents bit 0. The fall that follows is the
  // last one in the frame.
  logic                  r_last_bit;

  logic                  w_accept;
  logic                  w_run;
  logic                  w_rise_tick;
  logic                  w_fall_tick;
  logic [4:0]            w_bright;
  logic [FRAME_BITS-1:0] w_load_word;

`ifdef DOLED_BRIGHTNESS_EN
  assign w_bright = brightness_input;
`else
  assign w_bright = 5'b11111;
`endif

  // An invalid type never leaves IDLE, so it cannot raise busy or start sck.
  assign w_accept = (r_state == ST_IDLE) && doled_start &&
                    (type_input != INPUT_TYPE_INVALID);
  assign w_run    = (r_state == ST_SHIFT);

  // NOTE: every combinational output gets a default before the case. This
  // keeps an unlisted selector value from inferring a latch.
  always_comb begin
    w_load_word = '0;
    case (type_input)
      INPUT_TYPE_START: w_load_word = START_WORD;
      INPUT_TYPE_LED:   w_load_word = led_word(w_bright, blue_input,
                                               green_input, red_input);
      INPUT_TYPE_END:   w_load_word = END_WORD;
      default:          w_load_word = '0;
    endcase
  end

  doled_sck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_div (
    .i_clk       (doled_clk),
    .i_reset     (doled_reset),
    .i_run       (w_run),
    .o_sck       (sck),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  // The shift register holds the remaining frame, and its MSB is the line. At
  // accept, bit 31 appears on mosi immediately. Each fall moves the next bit
  // up. Clearing the register at frame end or reset parks mosi at 0.
  always_ff @(posedge doled_clk) begin
    if (doled_reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= 5'd0;
      r_last_bit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SHIFT;
            r_shift    <= w_load_word;
            r_bit_cnt  <= 5'd31;
            r_last_bit <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_rise_tick) begin
            r_last_bit <= (r_bit_cnt == 5'd0);
          end
          if (w_fall_tick) begin
            if (r_last_bit) begin
              r_state    <= ST_IDLE;
              r_shift    <= '0;
              r_bit_cnt  <= 5'd0;
              r_last_bit <= 1'b0;
            end else begin
              r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign doled_busy = (r_state == ST_SHIFT);
  assign mosi       = r_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_doled_serializer.sv
// -----------------------------------------------------------------------------
// tb_doled_serializer
//
// Directed testbench for doled_serializer with CLK_DIV = 2. Bits are captured
// at sck rising edges, and busy duration and accept-to-accept period are
// measured in clock edges. Expected frame words are written out by hand.
// -----------------------------------------------------------------------------
module tb_doled_serializer;

  logic       doled_clk = 1'b0;
  logic       doled_reset;
  logic       doled_start;
  logic [1:0] type_input;
  logic [7:0] blue_input;
  logic [7:0] green_input;
  logic [7:0] red_input;
`ifdef DOLED_BRIGHTNESS_EN
  logic [4:0] brightness_input;
`endif
  logic       doled_busy;
  logic       mosi;
  logic       sck;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 doled_clk = ~doled_clk;
  always @(posedge doled_clk) cyc++;

  doled_serializer #(
    .CLK_DIV    (2),
    .START_WORD (32'h0000_0000),
    .END_WORD   (32'hFFFF_FFFF)
  ) dut (
    .doled_clk        (doled_clk),
    .doled_reset      (doled_reset),
    .doled_start      (doled_start),
    .type_input       (type_input),
    .blue_input       (blue_input),
    .green_input      (green_input),
    .red_input        (red_input),
`ifdef DOLED_BRIGHTNESS_EN
    .brightness_input (brightness_input),
`endif
    .doled_busy       (doled_busy),
    .mosi             (mosi),
    .sck              (sck)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge doled_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] b,
                      input logic [7:0] g, input logic [7:0] r,
                      output int accept_cyc);
    doled_start = 1'b1;
    type_input  = t;
    blue_input  = b;
    green_input = g;
    red_input   = r;
    tick();
    accept_cyc  = cyc;
    doled_start = 1'b0;
  endtask

  // Runs until busy drops, with a cycle budget. When poke_at >= 0, it raises
  // a new LED request with different colours for one cycle mid-frame.
  task automatic capture(input int poke_at, output logic [31:0] word,
                         output int busy_cyc, output int glitches);
    logic prev_sck;
    logic prev_mosi;
    int   n;
    word      = '0;
    busy_cyc  = 0;
    glitches  = 0;
    n         = 0;
    prev_sck  = sck;
    prev_mosi = mosi;
    while (doled_busy && n < 1000) begin
      if (!prev_sck && sck) word = {word[30:0], mosi};
      if (mosi !== prev_mosi && !(prev_sck && !sck)) glitches++;
      if (n == poke_at) begin
        doled_start = 1'b1;
        type_input  = 2'd1;
        blue_input  = 8'h00;
        green_input = 8'h00;
        red_input   = 8'h00;
      end else begin
        doled_start = 1'b0;
      end
      busy_cyc++;
      n++;
      prev_sck  = sck;
      prev_mosi = mosi;
      tick();
    end
    doled_start = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          busy_cyc;
    int          glitches;
    int          acc_a;
    int          acc_b;
    logic        any_bad;

    doled_reset = 1'b1;
    doled_start = 1'b0;
    type_input  = 2'd0;
    blue_input  = 8'h00;
    green_input = 8'h00;
    red_input   = 8'h00;
`ifdef DOLED_BRIGHTNESS_EN
    brightness_input = 5'b11111;
`endif
    repeat (3) tick();
    check("reset_busy", 32'(doled_busy), 32'd0);
    check("reset_sck",  32'(sck),        32'd0);
    check("reset_mosi", 32'(mosi),       32'd0);
    doled_reset = 1'b0;

    // Idle hold of 100 cycles: all outputs must stay low.
    any_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (doled_busy !== 1'b0 || sck !== 1'b0 || mosi !== 1'b0) any_bad = 1'b1;
    end
    check("idle_100", 32'(any_bad), 32'd0);

    // LED frame B=12 G=34 R=56 with brightness 11111 -> FF123456.
`ifdef DOLED_BRIGHTNESS_EN
    brightness_input = 5'b11111;
`endif
    send(2'd1, 8'h12, 8'h34, 8'h56, acc_a);
    check("led_first_busy", 32'(doled_busy), 32'd1);
    check("led_first_sck",  32'(sck),        32'd0);
    check("led_first_mosi", 32'(mosi),       32'd1);
    // Inputs change after accept; the frame in flight must not follow them.
    blue_input  = 8'h00;
    green_input = 8'h00;
    red_input   = 8'h00;
    capture(-1, word, busy_cyc, glitches);
    check("led_word",     word,     32'hFF12_3456);
    check("led_busy_len", busy_cyc, 32'd128);
    check("led_mosi_chg", glitches, 32'd0);
    check("led_end_sck",  32'(sck),  32'd0);
    check("led_end_mosi", 32'(mosi), 32'd0);

    // START, then END requested on the first busy-low cycle.
    send(2'd0, 8'h00, 8'h00, 8'h00, acc_a);
    check("start_mosi0", 32'(mosi), 32'd0);
    capture(-1, word, busy_cyc, glitches);
    check("start_word", word,     32'h0000_0000);
    check("start_busy", busy_cyc, 32'd128);
    send(2'd2, 8'h00, 8'h00, 8'h00, acc_b);
    check("period", 32'(acc_b - acc_a), 32'd129);
    check("end_busy_on", 32'(doled_busy), 32'd1);
    capture(-1, word, busy_cyc, glitches);
    check("end_word", word,     32'hFFFF_FFFF);
    check("end_busy", busy_cyc, 32'd128);

    // A request mid-frame is ignored and not queued.
    send(2'd1, 8'hAA, 8'h55, 8'h0F, acc_a);
    capture(40, word, busy_cyc, glitches);
    check("poke_word", word,     32'hFFAA_550F);
    check("poke_busy", busy_cyc, 32'd128);
    any_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (doled_busy !== 1'b0 || sck !== 1'b0) any_bad = 1'b1;
    end
    check("poke_no_queue", 32'(any_bad), 32'd0);

    // An invalid type gives no busy and no sck activity.
    doled_start = 1'b1;
    type_input  = 2'd3;
    any_bad     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (doled_busy !== 1'b0 || sck !== 1'b0) any_bad = 1'b1;
    end
    doled_start = 1'b0;
    check("invalid_ignored", 32'(any_bad), 32'd0);

    // Reset at bit 10 of an LED frame. Each bit takes 4 cycles, and 21 bits
    // are done after 84 cycles.
    send(2'd1, 8'hFF, 8'hFF, 8'hFF, acc_a);
    repeat (85) tick();
    check("pre_reset_busy", 32'(doled_busy), 32'd1);
    doled_reset = 1'b1;
    doled_start = 1'b1;       // same-cycle request must be dropped
    type_input  = 2'd2;
    tick();
    check("rst_mid_busy", 32'(doled_busy), 32'd0);
    check("rst_mid_sck",  32'(sck),        32'd0);
    check("rst_mid_mosi", 32'(mosi),       32'd0);
    doled_reset = 1'b0;
    doled_start = 1'b0;
    tick();
    check("rst_drop_req", 32'(doled_busy), 32'd0);
    send(2'd0, 8'h00, 8'h00, 8'h00, acc_a);
    capture(-1, word, busy_cyc, glitches);
    check("post_rst_word", word,     32'h0000_0000);
    check("post_rst_busy", busy_cyc, 32'd128);

`ifdef DOLED_BRIGHTNESS_EN
    brightness_input = 5'b00101;
    send(2'd1, 8'h00, 8'h00, 8'h00, acc_a);
    brightness_input = 5'b11111;
    capture(-1, word, busy_cyc, glitches);
    check("bright_word", word, 32'hE500_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
